// File: rtl/lieat_general_sram_fifo_pkg.sv
// rtl/lieat_general_sram_fifo_pkg.sv - shared data width, legal SRAM address widths and word type
package lieat_general_sram_fifo_pkg;

  localparam int DATA_W   = 64;
  localparam int AW_SMALL = 6;
  localparam int AW_MID   = 7;
  localparam int AW_LARGE = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/lieat_general_sram_fifo_if.sv
// rtl/lieat_general_sram_fifo_if.sv - push/pop handshake and occupancy bundle for the SRAM FIFO
interface lieat_general_sram_fifo_if
  import lieat_general_sram_fifo_pkg::*;
#(
  parameter int AW = 6
);

  logic        in_valid;
  logic        in_ready;
  data_t       in_data;
  logic        out_valid;
  logic        out_ready;
  data_t       out_data;
  logic [AW:0] level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );

endinterface

// File: rtl/lieat_general_sram_fifo_sram.sv
// rtl/lieat_general_sram_fifo_sram.sv - single-port 64-bit SRAMs, one per legal depth
// Read data is combinational from the address; writes are blocked while reset is held.
module lieat_general_64x64_sram
  import lieat_general_sram_fifo_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wen,
  input  logic [5:0] i_a,
  input  data_t      i_d,
  output data_t      o_q
);

  data_t r_mem [64];

  always_ff @(posedge i_clock) begin
    if (i_wen && !i_reset) r_mem[i_a] <= i_d;
  end

  assign o_q = r_mem[i_a];

endmodule

module lieat_general_128x64_sram
  import lieat_general_sram_fifo_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wen,
  input  logic [6:0] i_a,
  input  data_t      i_d,
  output data_t      o_q
);

  data_t r_mem [128];

  always_ff @(posedge i_clock) begin
    if (i_wen && !i_reset) r_mem[i_a] <= i_d;
  end

  assign o_q = r_mem[i_a];

endmodule

module lieat_general_256x64_sram
  import lieat_general_sram_fifo_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_wen,
  input  logic [7:0] i_a,
  input  data_t      i_d,
  output data_t      o_q
);

  data_t r_mem [256];

  always_ff @(posedge i_clock) begin
    if (i_wen && !i_reset) r_mem[i_a] <= i_d;
  end

  assign o_q = r_mem[i_a];

endmodule

// File: rtl/lieat_general_sram_fifo.sv
// rtl/lieat_general_sram_fifo.sv - FIFO built from one single-port SRAM plus a registered head word
// The output register holds the head; the SRAM holds everything behind it.
module lieat_general_sram_fifo
  import lieat_general_sram_fifo_pkg::*;
#(
  parameter int AW = 6
)(
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  lieat_general_sram_fifo_if.slave  bus
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_sram_cnt;
  logic          r_out_valid;
  data_t         r_out_data;

  logic          w_pop;
  logic          w_slot_free;
  logic          w_cnt_nz;
  logic          w_full;
  logic          w_rd;
  logic          w_byp;
  logic          w_in_ready;
  logic          w_wr;
  logic          w_wen;
  logic [AW-1:0] w_addr;
  data_t         w_q;

  assign w_pop       = r_out_valid & bus.out_ready;
  assign w_slot_free = !r_out_valid | w_pop;
  assign w_cnt_nz    = (r_sram_cnt != '0);
  assign w_full      = (r_sram_cnt == {1'b1, {AW{1'b0}}});
  assign w_rd        = w_slot_free & w_cnt_nz;
  assign w_byp       = w_slot_free & !w_cnt_nz & bus.in_valid;
  // A head refill from the SRAM owns the single port, so the push waits.
  assign w_in_ready  = !i_reset & !i_flush & !w_rd & !w_full;
  assign w_wr        = bus.in_valid & w_in_ready & !w_byp;
  assign w_wen       = w_wr;
  assign w_addr      = w_rd ? r_rd_ptr : r_wr_ptr;

  generate
    if (AW == AW_SMALL) begin : g_sram64
      lieat_general_64x64_sram u_sram (
        .i_clock (i_clock), .i_reset (i_reset), .i_wen (w_wen),
        .i_a     (w_addr),  .i_d     (bus.in_data), .o_q (w_q)
      );
    end else if (AW == AW_MID) begin : g_sram128
      lieat_general_128x64_sram u_sram (
        .i_clock (i_clock), .i_reset (i_reset), .i_wen (w_wen),
        .i_a     (w_addr),  .i_d     (bus.in_data), .o_q (w_q)
      );
    end else if (AW == AW_LARGE) begin : g_sram256
      lieat_general_256x64_sram u_sram (
        .i_clock (i_clock), .i_reset (i_reset), .i_wen (w_wen),
        .i_a     (w_addr),  .i_d     (bus.in_data), .o_q (w_q)
      );
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sram_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sram_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_rd) begin
        r_out_data  <= w_q;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end else if (w_byp) begin
        r_out_data  <= bus.in_data;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_wr)      r_sram_cnt <= r_sram_cnt + (AW+1)'(1);
      else if (w_rd) r_sram_cnt <= r_sram_cnt - (AW+1)'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.level     = r_sram_cnt + {{AW{1'b0}}, r_out_valid};

endmodule

// File: tb/tb_lieat_general_sram_fifo.sv
// tb/tb_lieat_general_sram_fifo.sv - queue-model and directed-vector bench for the SRAM FIFO
module tb_lieat_general_sram_fifo;
  import lieat_general_sram_fifo_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  lieat_general_sram_fifo_if #(.AW(AW)) bus ();

  lieat_general_sram_fifo #(.AW(AW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  int    checks = 0;
  int    errors = 0;
  bit    mon_on = 1'b0;
  data_t q[$];
  data_t popped[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Model: the FIFO is an ordered queue; the head is visible whenever it is non-empty.
  // Everything behind the head lives in the SRAM, and a push is refused while the
  // consumer is pulling a word out of the SRAM or when the SRAM is full.
  always @(negedge clk) begin
    int cnt;
    bit exp_rdy;
    bit exp_wen;
    bit do_pop;
    if (mon_on) begin
      cnt     = q.size();
      exp_rdy = !rst && !flush &&
                (cnt == 0 || (!(bus.out_ready && cnt >= 2) && (cnt - 1) != DEPTH));
      exp_wen = bus.in_valid && exp_rdy && !(cnt == 0 || (cnt == 1 && bus.out_ready));
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, cnt > 0);
      chk("level", bus.level, cnt);
      if (cnt > 0) chk("out_data", bus.out_data, q[0]);
      chk("sram_wen", dut.w_wen, exp_wen);
      if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
      if (rst || flush) begin
        q.delete();
      end else begin
        do_pop = (cnt > 0) && bus.out_ready;
        if (do_pop) void'(q.pop_front());
        if (bus.in_valid && exp_rdy) q.push_back(bus.in_data);
      end
    end
  end

  task automatic clear_case(input bit use_rst);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (70) next();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 64'(300 + i);
      next();
    end
    bus.in_data   = 64'h777;
    bus.out_ready = 1'b1;
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    @(negedge clk);
    chk(use_rst ? "rst_pre_level" : "flush_pre_level", bus.level, 10);
    next();
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk(use_rst ? "rst_level" : "flush_level", bus.level, 0);
    chk(use_rst ? "rst_out_valid" : "flush_out_valid", bus.out_valid, 0);
    next();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1;
    next();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("after_clear_data", bus.out_data, 64'h1);
    chk("after_clear_level", bus.level, 1);
    next();
    @(negedge clk);
    chk("after_clear_alone", bus.level, 1);
    bus.out_ready = 1'b1;
    next();
    @(negedge clk);
    chk("after_clear_empty", bus.level, 0);
  endtask

  initial begin
    int  k;
    bit  acc;
    int  n;
    data_t exp_seq[5];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    next();
    mon_on = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_level", bus.level, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);

    // Bypass of a single word into an empty FIFO
    next();
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hA5;
    bus.out_ready = 1'b1;
    next();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bypass_valid", bus.out_valid, 1);
    chk("bypass_data", bus.out_data, 64'hA5);
    next();

    // Fill to DEPTH+1 with the consumer stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    k = 0;
    repeat (70) begin
      bus.in_data = 64'(k);
      @(negedge clk);
      acc = bus.in_ready;
      next();
      if (acc) k++;
    end
    @(negedge clk);
    chk("fill_accepted", k, 65);
    chk("fill_level", bus.level, 65);
    chk("fill_in_ready", bus.in_ready, 0);
    next();

    // Drain in order, one word per cycle
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_data", bus.out_data, 64'(i));
      next();
    end
    @(negedge clk);
    chk("drain_level", bus.level, 0);
    chk("drain_out_valid", bus.out_valid, 0);
    next();

    // Contention: three words in the SRAM while a push is offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int v = 100; v < 104; v++) begin
      bus.in_data = 64'(v);
      next();
    end
    bus.in_data   = 64'd200;
    bus.out_ready = 1'b1;
    popped.delete();
    @(negedge clk);
    chk("contention_in_ready", bus.in_ready, 0);
    acc = bus.in_ready;
    n = 0;
    while (!acc && n < 20) begin
      next();
      @(negedge clk);
      acc = bus.in_ready;
      n++;
    end
    chk("contention_accept", acc, 1);
    chk("contention_wait", n, 3);
    next();
    bus.in_valid = 1'b0;
    repeat (4) next();
    exp_seq = '{64'd100, 64'd101, 64'd102, 64'd103, 64'd200};
    chk("contention_count", popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) chk("contention_order", popped[i], exp_seq[i]);

    // Random push/pop traffic with pointer wrap
    for (int c = 0; c < 200; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 70);
      bus.in_data   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 99) < 60);
      next();
    end

    clear_case(1'b0);
    clear_case(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/lieat_general_sram_fifo.md
LIEAT_GENERAL_SRAM_FIFO -- requirements
Module: lieat_general_sram_fifo

Interface
REQ-001: Parameter AW, default 6, SHALL be the SRAM address width; legal values 6, 7, 8; DEPTH = 2^AW.
REQ-002: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: reset  input  1  SHALL be synchronous, active-high reset.
REQ-004: flush  input  1  SHALL be a synchronous clear of all FIFO state.
REQ-005: in_valid  input  1  SHALL flag a push request.
REQ-006: in_ready  output  1  SHALL flag that the push is accepted this cycle.
REQ-007: in_data  input  64  SHALL carry the push data word.
REQ-008: out_valid  output  1  SHALL flag that out_data holds the head entry.
REQ-009: out_ready  input  1  SHALL flag that the consumer takes out_data this cycle.
REQ-010: out_data  output  64  SHALL carry the head entry, driven directly from a register.
REQ-011: level  output  AW+1  SHALL report total occupancy, equal to sram_cnt + out_valid, range 0..DEPTH+1.

Function
REQ-012: Storage SHALL be one single-port SRAM (WEn, A, D, Q; combinational Q) plus one 64-bit output register; total capacity SHALL be DEPTH+1.
REQ-013: State SHALL be wr_ptr[AW-1:0], rd_ptr[AW-1:0], sram_cnt[AW:0], out_valid, and out_data.
REQ-014: Per-cycle terms SHALL be: pop = out_valid & out_ready; slot_free = !out_valid | pop; rd = slot_free & (sram_cnt != 0); byp = slot_free & (sram_cnt == 0) & in_valid.
REQ-015: in_ready SHALL equal !flush & !rd & (sram_cnt != DEPTH); it is combinational from out_ready and state.
REQ-016: Write condition: wr = in_valid & in_ready & !byp.
REQ-017: Bypass condition: byp SHALL load in_data into out_data without an SRAM access.
REQ-018: SRAM port SHALL be driven as WEn = wr; A = rd ? rd_ptr : wr_ptr; D = in_data.
REQ-019: rd and wr SHALL never both be true in one cycle; a pending read has priority over a push.
REQ-020: On rd, out_data SHALL load Q, out_valid SHALL be 1, rd_ptr SHALL increment, and sram_cnt SHALL decrement.
REQ-021: On wr, wr_ptr SHALL increment and sram_cnt SHALL increment.
REQ-022: Pointers SHALL wrap modulo DEPTH with no special case.
REQ-023: If neither rd nor byp occurs and pop is true, out_valid SHALL clear; out_data holds its value.
REQ-024: Latency SHALL be 1 cycle from an accepted push to out_valid when the FIFO is empty (bypass path).
REQ-025: Sustained throughput SHALL be 1 word per cycle while sram_cnt == 0 and the consumer accepts every cycle.
REQ-026: Full: with sram_cnt == DEPTH and no rd, in_ready SHALL be 0.
REQ-027: Empty: with out_valid == 0 and in_valid == 0, no SRAM access SHALL occur (WEn = 0).
REQ-028: Order SHALL be strict FIFO in all cases, including a bypass that follows an SRAM drain.
REQ-029: flush SHALL clear wr_ptr, rd_ptr, sram_cnt and out_valid next cycle, dominating all push/pop that cycle.
REQ-030: flush SHALL NOT clear SRAM contents.

Reset
REQ-031: reset SHALL give wr_ptr=0, rd_ptr=0, sram_cnt=0, out_valid=0, out_data=0, so level=0.
REQ-032: During reset, in_ready SHALL be 0 and WEn SHALL be 0.
REQ-033: reset asserted mid-stream SHALL discard all entries; the first post-reset push SHALL take the bypass path.
REQ-034: The SRAM instance SHALL receive the same clock and reset.

Structure
REQ-035: A shared package SHALL hold the data width constant (64) and the legal AW set.
REQ-036: The block SHALL contain one sub-module: the general SRAM selected by AW — lieat_general_64x64_sram, lieat_general_128x64_sram or lieat_general_256x64_sram — chosen with a generate on AW.
REQ-037: All other logic SHALL be flat within lieat_general_sram_fifo.

Verification
REQ-038: Bypass: AW=6, empty, push 0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 next cycle; WEn never 1.
REQ-039: Fill: out_ready=0, push 0..64 -> all 65 accepted, level=65, in_ready=0; the 66th word is held off.
REQ-040: Drain: from full, out_ready=1 -> outputs 0..64 in order, one per cycle; then level=0 and out_valid=0.
REQ-041: Contention: sram_cnt=3, out_ready=1, in_valid=1 -> in_ready=0 while rd occurs; the push lands once sram_cnt=0 via bypass; order preserved.
REQ-042: Wrap: 200 random push/pop cycles, AW=6, pointers wrapping several times -> scoreboard match, level always consistent.
REQ-043: Flush/reset: flush (then separately reset) with level=10 and simultaneous push/pop -> level=0, out_valid=0 next cycle; the next push 0x1 emerges alone.
